// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit saturating-counter branch predictor.
package bp_pkg;

    localparam int AWIDTH = 30;
    localparam int DWIDTH = 2;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == STRONG_T) ? STRONG_T : ctr + 2'd1;
        else
            return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_cache.sv
// Direct-mapped tagged store: two asynchronous read ports, one clocked write port,
// synchronous active-high clear of the valid bits.
module bp_cache #(
    parameter int AWIDTH = 30,
    parameter int DWIDTH = 2,
    parameter int LINES  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout0,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit0,
    output logic              hit1,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din,
    input  logic              we
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = AWIDTH - IDXW;

    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [DWIDTH-1:0] r_data [LINES];

    logic [IDXW-1:0] w_idx0, w_idx1, w_widx;

    assign w_idx0 = ra0[IDXW-1:0];
    assign w_idx1 = ra1[IDXW-1:0];
    assign w_widx = wa[IDXW-1:0];

    assign hit0  = r_valid[w_idx0] && (r_tag[w_idx0] == ra0[AWIDTH-1:IDXW]);
    assign hit1  = r_valid[w_idx1] && (r_tag[w_idx1] == ra1[AWIDTH-1:IDXW]);
    assign dout0 = r_data[w_idx0];
    assign dout1 = r_data[w_idx1];

    always_ff @(posedge clk) begin
        if (reset)
            r_valid <= '0;
        else if (we)
            r_valid[w_widx] <= 1'b1;
    end

    // NOTE: tag/data arrays are deliberately not reset; a cleared valid bit makes their contents unobservable.
    always_ff @(posedge clk) begin
        if (we) begin
            r_tag[w_widx]  <= wa[AWIDTH-1:IDXW];
            r_data[w_widx] <= din;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter predictor: zero-latency guess path, one-cycle write-back
// check path with pending-register forwarding, and saturating branch statistics.
module branch_predictor #(
    parameter int LINES = 128,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_guess,
    input  logic             is_br_guess,
    output logic             br_taken,
    input  logic [31:0]      pc_check,
    input  logic             is_br_check,
    input  logic             br_taken_check,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    import bp_pkg::*;

    logic              r_pend_valid;
    logic [AWIDTH-1:0] r_pend_addr;
    logic [1:0]        r_pend_ctr;
    logic [CNT_W-1:0]  r_br_count;
    logic [CNT_W-1:0]  r_mispred_count;

    logic [DWIDTH-1:0] w_dout0, w_dout1;
    logic              w_hit0, w_hit1, w_we;
    logic [1:0]        w_guess_ctr, w_cur_ctr, w_next_ctr;
    logic              w_fwd_guess, w_fwd_check, w_pred, w_mispred;
    logic              w_unused;

    assign w_unused = ^{pc_guess[1:0], pc_check[1:0]};

    // A pending write must not land in the cache while reset is asserted.
    assign w_we = r_pend_valid & reset;

    bp_cache #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH),
        .LINES (LINES)
    ) u_cache (
        .clk  (clk),
        .reset(~reset),
        .ra0  (pc_guess[31:2]),
        .ra1  (pc_check[31:2]),
        .dout0(w_dout0),
        .dout1(w_dout1),
        .hit0 (w_hit0),
        .hit1 (w_hit1),
        .wa   (r_pend_addr),
        .din  (r_pend_ctr),
        .we   (w_we)
    );

    assign w_fwd_guess = r_pend_valid && (r_pend_addr == pc_guess[31:2]);
    assign w_fwd_check = r_pend_valid && (r_pend_addr == pc_check[31:2]);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_guess_ctr = STRONG_NT;
        if (w_fwd_guess)
            w_guess_ctr = r_pend_ctr;
        else if (w_hit0)
            w_guess_ctr = w_dout0;
    end

    assign br_taken = is_br_guess & w_guess_ctr[1] & reset;

    always_comb begin
        w_cur_ctr  = w_fwd_check ? r_pend_ctr : w_dout1;
        w_next_ctr = br_taken_check ? WEAK_T : WEAK_NT;
        w_pred     = 1'b0;
        if (w_fwd_check || w_hit1) begin
            w_next_ctr = sat_update(w_cur_ctr, br_taken_check);
            w_pred     = w_cur_ctr[1];
        end
    end

    assign w_mispred = (w_pred != br_taken_check);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_valid    <= 1'b0;
            r_pend_addr     <= '0;
            r_pend_ctr      <= STRONG_NT;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            r_pend_valid <= is_br_check;
            r_pend_addr  <= pc_check[31:2];
            r_pend_ctr   <= w_next_ctr;
            if (is_br_check) begin
                if (r_br_count != '1)
                    r_br_count <= r_br_count + CNT_W'(1);
                if (w_mispred && (r_mispred_count != '1))
                    r_mispred_count <= r_mispred_count + CNT_W'(1);
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule
